fmul_share_ctrl: RTL and testbench

Sequencer/arbiter that shares one single-precision floating-point multiplier (fixed latency, registered integer core) between NREQ requesters, e.g. the FPU issue path and a debug/DMA port.
Accepts one operand pair at a time by round-robin, holds the operands stable on the multiplier for MUL_LAT cycles, captures product and overflow, and returns them to the owning requester with a valid/ready handshake.
Also keeps a sticky overflow status for the CPU.
One operation in flight; no pipelining.

---
 rtl/fmul_share_ctrl_pkg.sv | 18 +
 rtl/fmul_share_ctrl_if.sv | 23 ++
 rtl/fmul_rr_pick.sv | 23 ++
 rtl/fmul_share_ctrl.sv | 121 ++++++++++++
 tb/tb_fmul_share_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmul_share_ctrl_pkg.sv
// Shared definitions for the floating-point multiplier share controller:
// sequencer state encoding and FP32 field layout.
package fmul_share_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned FpWidth   = 32;
    localparam int unsigned FpSignBit = 31;
    localparam int unsigned FpExpMsb  = 30;
    localparam int unsigned FpExpLsb  = 23;
    localparam int unsigned FpManMsb  = 22;
    localparam int unsigned FpBias    = 127;

endpackage

// File: rtl/fmul_share_ctrl_if.sv
// Requester-side handshake bundle: operand request channel and result channel.
interface fmul_share_ctrl_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [31:0]        resp_c;
    logic               resp_ovf;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_c, resp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_c, resp_ovf
    );
endinterface

// File: rtl/fmul_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first valid requester
// found scanning upward from last+1 with wrap.
module fmul_rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IdxW = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IdxW-1:0] last,
    output logic [NREQ-1:0] grant
);
    logic [IdxW-1:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IdxW'((32'(last) + k) % NREQ);
            if (grant == '0 && req_valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fmul_share_ctrl.sv
// Shares one fixed-latency FP32 multiplier between NREQ requesters: round-robin
// accept, hold operands for MUL_LAT cycles, capture, return result by handshake.
module fmul_share_ctrl
    import fmul_share_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fmul_share_ctrl_if.slave   bus,
    output logic [FpWidth-1:0] mul_a,
    output logic [FpWidth-1:0] mul_b,
    input  logic [FpWidth-1:0] mul_c,
    input  logic               mul_ovf,
    output logic               busy,
    output logic               ovf_sticky,
    input  logic               ovf_clr
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e             state_q;
    logic [IdxW-1:0]    last_q;
    logic [IdxW-1:0]    owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NREQ-1:0]    resp_valid_q;
    logic [FpWidth-1:0] resp_c_q;
    logic               resp_ovf_q;

    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    req_ready;
    logic [IdxW-1:0]    grant_idx;
    logic               fire;
    logic               resp_ack;

    fmul_rr_pick #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_pick (
        .req_valid (bus.req_valid),
        .last      (last_q),
        .grant     (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = IdxW'(i);
            end
        end
    end

    // Grants are only offered while idle, so acceptance never overlaps a new grant.
    assign req_ready = (state_q == StIdle) ? grant : '0;
    assign fire      = |(bus.req_valid & req_ready);
    assign resp_ack  = (state_q == StResp) && bus.resp_ready[owner_q];

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_c     = resp_c_q;
    assign bus.resp_ovf   = resp_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_q       <= IdxW'(NREQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_c_q     <= '0;
            resp_ovf_q   <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            busy         <= 1'b0;
            ovf_sticky   <= 1'b0;
        end else begin
            if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (fire) begin
                        mul_a   <= bus.req_a[FpWidth*grant_idx +: FpWidth];
                        mul_b   <= bus.req_b[FpWidth*grant_idx +: FpWidth];
                        owner_q <= grant_idx;
                        last_q  <= grant_idx;
                        cnt_q   <= CNT_W'(MUL_LAT - 1);
                        busy    <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        resp_c_q     <= mul_c;
                        resp_ovf_q   <= mul_ovf;
                        resp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                        // Later assignment so a capture beats a same-cycle clear.
                        if (mul_ovf) begin
                            ovf_sticky <= 1'b1;
                        end
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ack) begin
                        resp_valid_q <= '0;
                        busy         <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Self-checking bench: three controller lanes (MUL_LAT 2, 1, 4) around a
// behavioural FP32 multiplier, with per-lane scoreboards and latency monitors.
module tb_fmul_share_ctrl;
    import fmul_share_ctrl_pkg::*;

    localparam int unsigned NREQ = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     resp_ready;
    logic                ovf_clr;

    logic [NREQ-1:0] rdy_w  [3];
    logic [NREQ-1:0] rv_w   [3];
    logic [31:0]     rc_w   [3];
    logic            rovf_w [3];
    logic [31:0]     mula_w [3];
    logic [31:0]     mulb_w [3];
    logic            busy_w [3];
    logic            stk_w  [3];
    int              pend   [3];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int grant_log [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [32:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[FpSignBit] ^ b[FpSignBit];
        if (a[FpExpMsb:FpExpLsb] == 8'd0 || b[FpExpMsb:FpExpLsb] == 8'd0) return {1'b0, s, 31'd0};
        p = {1'b1, a[FpManMsb:0]} * {1'b1, b[FpManMsb:0]};
        e = int'(a[FpExpMsb:FpExpLsb]) + int'(b[FpExpMsb:FpExpLsb]) - int'(FpBias);
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], m};
    endfunction

    function automatic int rr_model(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int unsigned L  = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int unsigned CW = (L == 1) ? 1 : 2;

        fmul_share_ctrl_if #(.NREQ(NREQ)) bus ();
        logic [31:0] mul_a, mul_b, mul_c;
        logic        mul_ovf, busy, ovf_sticky;
        logic [32:0] f_now;

        assign bus.req_valid  = req_valid;
        assign bus.req_a      = req_a;
        assign bus.req_b      = req_b;
        assign bus.resp_ready = (g == 0) ? resp_ready : '1;

        fmul_share_ctrl #(
            .NREQ    (NREQ),
            .MUL_LAT (L),
            .CNT_W   (CW)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .bus        (bus),
            .mul_a      (mul_a),
            .mul_b      (mul_b),
            .mul_c      (mul_c),
            .mul_ovf    (mul_ovf),
            .busy       (busy),
            .ovf_sticky (ovf_sticky),
            .ovf_clr    (ovf_clr)
        );

        assign f_now = fmul_model(mul_a, mul_b);
        if (L == 1) begin : g_comb
            assign {mul_ovf, mul_c} = f_now;
        end else begin : g_pipe
            logic [32:0] stg [L-1];
            always @(posedge clk) begin
                stg[0] <= f_now;
                for (int k = 1; k < int'(L) - 1; k++) stg[k] <= stg[k-1];
            end
            assign {mul_ovf, mul_c} = stg[L-2];
        end

        assign rdy_w[g]  = bus.req_ready;
        assign rv_w[g]   = bus.resp_valid;
        assign rc_w[g]   = bus.resp_c;
        assign rovf_w[g] = bus.resp_ovf;
        assign mula_w[g] = mul_a;
        assign mulb_w[g] = mul_b;
        assign busy_w[g] = busy;
        assign stk_w[g]  = ovf_sticky;

        logic [NREQ+32:0] sbq [$];
        logic [NREQ+32:0] ent;
        logic [NREQ-1:0]  oh;
        logic [31:0]      lat_a, lat_b;
        logic             rv_prev;
        int               last_m, prev_g, g_cyc, exp_i, act_i;

        always @(negedge clk) begin
            if (!rst_n) begin
                sbq.delete();
                last_m  = NREQ - 1;
                prev_g  = -1;
                rv_prev = 1'b0;
            end else begin
                if (busy) begin
                    chk("mul_a hold", mul_a, lat_a);
                    chk("mul_b hold", mul_b, lat_b);
                end
                if (|(bus.req_valid & bus.req_ready)) begin
                    chk("grant onehot", 32'($countones(bus.req_ready)), 1);
                    exp_i = rr_model(last_m, bus.req_valid);
                    oh = '0;
                    if (exp_i >= 0) oh[exp_i] = 1'b1;
                    chk("grant rr", 32'(bus.req_ready), 32'(oh));
                    act_i = -1;
                    for (int i = 0; i < int'(NREQ); i++) if (bus.req_ready[i]) act_i = i;
                    if (g == 0) grant_log.push_back(act_i);
                    last_m = exp_i;
                    lat_a  = req_a[32*exp_i +: 32];
                    lat_b  = req_b[32*exp_i +: 32];
                    if (prev_g >= 0) chk("grant spacing", 32'(cyc - prev_g >= int'(L) + 2), 1);
                    prev_g = cyc;
                    g_cyc  = cyc;
                    sbq.push_back({oh, fmul_model(lat_a, lat_b)});
                end
                if (bus.resp_valid != '0 && !rv_prev) chk("resp latency", 32'(cyc - g_cyc), L + 1);
                rv_prev = |bus.resp_valid;
                if (|(bus.resp_valid & bus.resp_ready)) begin
                    if (sbq.size() == 0) begin
                        chk("resp without op", 32'(sbq.size()), 1);
                    end else begin
                        ent = sbq.pop_front();
                        chk("resp owner", 32'(bus.resp_valid), 32'(ent[NREQ+32:33]));
                        chk("resp_c", bus.resp_c, ent[31:0]);
                        chk("resp_ovf", 32'(bus.resp_ovf), 32'(ent[32]));
                    end
                end
            end
            pend[g] = sbq.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        bit seen = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (|(req_valid & rdy_w[0])) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(seen), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_seq [4] = '{1, 0, 1, 0};
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(rdy_w[0]), 0);
        chk("rst resp_valid", 32'(rv_w[0]), 0);
        chk("rst resp_c", rc_w[0], 0);
        chk("rst resp_ovf", 32'(rovf_w[0]), 0);
        chk("rst mul_a", mula_w[0], 0);
        chk("rst mul_b", mulb_w[0], 0);
        chk("rst busy", 32'(busy_w[0]), 0);
        chk("rst sticky", 32'(stk_w[0]), 0);
        step(); rst_n = 1'b1; step();

        // Single op: 2.0 * 3.0 on requester 0.
        req_a[31:0] = 32'h4000_0000; req_b[31:0] = 32'h4040_0000; req_valid = 2'b01;
        wait_grant("single grant");
        chk("single ready", 32'(rdy_w[0]), 32'b01);
        step();
        chk("T+1 ready", 32'(rdy_w[0]), 0);
        chk("T+1 busy", 32'(busy_w[0]), 1);
        step();
        chk("T+2 ready", 32'(rdy_w[0]), 0);
        chk("T+2 resp_valid", 32'(rv_w[0]), 0);
        step();
        chk("T+3 ready", 32'(rdy_w[0]), 0);
        chk("T+3 resp_valid", 32'(rv_w[0]), 32'b01);
        chk("T+3 resp_c", rc_w[0], 32'h40C0_0000);
        chk("T+3 resp_ovf", 32'(rovf_w[0]), 0);
        resp_ready = 2'b01; req_valid = '0;
        step();
        chk("T+4 resp_valid", 32'(rv_w[0]), 0);
        chk("T+4 busy", 32'(busy_w[0]), 0);

        // Contention: 1.5*1.5 on req0, 2.0*2.0 on req1.
        grant_log.delete();
        req_a = {32'h4000_0000, 32'h3FC0_0000};
        req_b = {32'h4000_0000, 32'h3FC0_0000};
        req_valid = 2'b11; resp_ready = 2'b11;
        repeat (18) step();
        req_valid = '0;
        repeat (8) step();
        chk("rr log size", 32'(grant_log.size() >= 4), 1);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("rr order", grant_log[k], exp_seq[k]);

        // Backpressure: owner 0 stalls, non-owner ready must be ignored.
        req_a[31:0] = 32'h4040_0000; req_b[31:0] = 32'h4040_0000;
        req_valid = 2'b01; resp_ready = 2'b10;
        wait_grant("bp grant");
        step();
        req_valid = 2'b11;
        for (int i = 0; i < 10 && rv_w[0] == '0; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("bp resp_valid", 32'(rv_w[0]), 32'b01);
            chk("bp resp_c", rc_w[0], 32'h4110_0000);
            chk("bp ready", 32'(rdy_w[0]), 0);
            step();
        end
        resp_ready = 2'b01;
        #1;
        chk("accept-cycle ready", 32'(rdy_w[0]), 0);
        step();
        chk("post-accept ready", 32'(rdy_w[0]), 32'b10);
        chk("post-accept resp_valid", 32'(rv_w[0]), 0);
        req_valid = '0; resp_ready = 2'b11;
        step();

        // Overflow capture and sticky flag.
        req_a[31:0] = 32'h7F00_0000; req_b[31:0] = 32'h7F00_0000; req_valid = 2'b01;
        wait_grant("ovf grant");
        step(); req_valid = '0;
        step();
        chk("ovf sticky pre", 32'(stk_w[0]), 0);
        step();
        chk("ovf resp_valid", 32'(rv_w[0]), 32'b01);
        chk("ovf resp_ovf", 32'(rovf_w[0]), 1);
        chk("ovf sticky set", 32'(stk_w[0]), 1);
        step();
        req_valid = 2'b01;
        wait_grant("ovf2 grant");
        step(); req_valid = '0;
        step(); ovf_clr = 1'b1;
        step(); ovf_clr = 1'b0;
        chk("set beats clr", 32'(stk_w[0]), 1);
        step(); ovf_clr = 1'b1;
        step(); ovf_clr = 1'b0;
        chk("clr alone", 32'(stk_w[0]), 0);

        // Reset while busy discards the operation and restores priority.
        req_a[31:0] = 32'h4000_0000; req_b[31:0] = 32'h4000_0000; req_valid = 2'b01;
        wait_grant("rst-op grant");
        step(); req_valid = '0; rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy_w[0]), 0);
        chk("midrst mul_a", mula_w[0], 0);
        chk("midrst resp_c", rc_w[0], 0);
        chk("midrst resp_valid", 32'(rv_w[0]), 0);
        step(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no stale resp", 32'(rv_w[0]), 0);
        end
        req_valid = 2'b11;
        #1;
        chk("post-rst grant", 32'(rdy_w[0]), 32'b01);
        step(); req_valid = '0;
        repeat (10) step();
        for (int g = 0; g < 3; g++) chk("drained", 32'(pend[g]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
